riscv_dift_tag_unit: RTL and testbench

- EX-stage companion to the ALU for dynamic information flow tracking (DIFT).
- Takes the instruction class and operand tags produced by the ID-stage decoder.
- Evaluates the Tag Check Register (TCR) and Tag Propagation Register (TPR) policy, then registers the result tag for write-back.
- On a policy violation it raises a security exception to the controller, using a req/ack handshake, and stalls the pipeline until the exception is acknowledged.

---
 rtl/riscv_dift_tag_unit_pkg.sv | 92 +++++++++
 rtl/riscv_dift_tag_unit_prio_enc.sv | 21 ++
 rtl/riscv_dift_tag_unit.sv | 176 +++++++++++++++++
 tb/tb_riscv_dift_tag_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dift_tag_unit_pkg.sv
// Shared DIFT definitions: instruction classes, TCR/TPR bit layout, propagation
// modes and the tag-unit FSM states.
package riscv_dift_tag_unit_pkg;

  localparam int unsigned TCR_WIDTH = 22;
  localparam int unsigned TPR_WIDTH = 18;

  typedef enum logic [2:0] {
    CLASS_INT     = 3'd0,
    CLASS_BRANCH  = 3'd1,
    CLASS_JUMP    = 3'd2,
    CLASS_SHIFT   = 3'd3,
    CLASS_CMP     = 3'd4,
    CLASS_LOGICAL = 3'd5,
    CLASS_LOAD    = 3'd6,
    CLASS_STORE   = 3'd7
  } dift_class_e;

  typedef enum logic [1:0] {
    RUN,
    REQ,
    FLUSH
  } dift_state_e;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd_old;
    logic mem;
    logic pc;
  } dift_tags_t;

  // TCR check-enable bit indices; jumps only check their source register.
  localparam int unsigned INT_CHECK_S1     = 0;
  localparam int unsigned INT_CHECK_S2     = 1;
  localparam int unsigned INT_CHECK_D      = 2;
  localparam int unsigned BRANCH_CHECK_S1  = 3;
  localparam int unsigned BRANCH_CHECK_S2  = 4;
  localparam int unsigned JUMP_CHECK_S1    = 5;
  localparam int unsigned SHIFT_CHECK_S1   = 6;
  localparam int unsigned SHIFT_CHECK_S2   = 7;
  localparam int unsigned SHIFT_CHECK_D    = 8;
  localparam int unsigned CMP_CHECK_S1     = 9;
  localparam int unsigned CMP_CHECK_S2     = 10;
  localparam int unsigned CMP_CHECK_D      = 11;
  localparam int unsigned LOGICAL_CHECK_S1 = 12;
  localparam int unsigned LOGICAL_CHECK_S2 = 13;
  localparam int unsigned LOGICAL_CHECK_D  = 14;
  localparam int unsigned LOAD_CHECK_S     = 15;
  localparam int unsigned LOAD_CHECK_SA    = 16;
  localparam int unsigned LOAD_CHECK_D     = 17;
  localparam int unsigned STORE_CHECK_S    = 18;
  localparam int unsigned STORE_CHECK_D    = 19;
  localparam int unsigned STORE_CHECK_DA   = 20;
  localparam int unsigned EXECUTE_PC       = 21;

  // TPR propagation-mode field bit indices; bit 14 is reserved.
  localparam int unsigned TPR_INT_LOW       = 0;
  localparam int unsigned TPR_INT_HIGH      = 1;
  localparam int unsigned TPR_JUMP_LOW      = 2;
  localparam int unsigned TPR_JUMP_HIGH     = 3;
  localparam int unsigned TPR_SHIFT_LOW     = 4;
  localparam int unsigned TPR_SHIFT_HIGH    = 5;
  localparam int unsigned TPR_CMP_LOW       = 6;
  localparam int unsigned TPR_CMP_HIGH      = 7;
  localparam int unsigned TPR_LOGICAL_LOW   = 8;
  localparam int unsigned TPR_LOGICAL_HIGH  = 9;
  localparam int unsigned TPR_STORE_LOW     = 10;
  localparam int unsigned TPR_STORE_HIGH    = 11;
  localparam int unsigned TPR_LOAD_LOW      = 12;
  localparam int unsigned TPR_LOAD_HIGH     = 13;
  localparam int unsigned TPR_STORE_DATA_EN = 15;
  localparam int unsigned TPR_LOAD_ADDR_EN  = 16;
  localparam int unsigned TPR_STORE_ADDR_EN = 17;

  localparam logic [1:0] ALU_MODE_OLD   = 2'b00;
  localparam logic [1:0] ALU_MODE_AND   = 2'b01;
  localparam logic [1:0] ALU_MODE_OR    = 2'b10;
  localparam logic [1:0] ALU_MODE_CLEAR = 2'b11;

  function automatic logic prop_result(logic [1:0] mode, logic a, logic b, logic old);
    logic r;
    case (mode)
      ALU_MODE_AND:   r = a & b;
      ALU_MODE_OR:    r = a | b;
      ALU_MODE_CLEAR: r = 1'b0;
      default:        r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_dift_tag_unit_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit flag; selects the violated
// check reported as the security exception cause.
module riscv_dift_prio_enc #(
  parameter int unsigned WIDTH     = 22,
  parameter int unsigned IDX_WIDTH = 5
) (
  input  logic [WIDTH-1:0]     vec_i,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  always_comb begin
    idx_o = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (vec_i[i-1]) idx_o = IDX_WIDTH'(i - 1);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/riscv_dift_tag_unit.sv
// EX-stage DIFT tag unit: TCR violation check, TPR tag propagation and the
// security-exception req/ack handshake with pipeline stall.
module riscv_dift_tag_unit
  import riscv_dift_tag_unit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned CAUSE_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TCR_WIDTH-1:0]   tcr_i,
  input  logic [TPR_WIDTH-1:0]   tpr_i,
  input  logic                   valid_i,
  input  logic [2:0]             class_i,
  input  logic                   tag_rs1_i,
  input  logic                   tag_rs2_i,
  input  logic                   tag_rd_old_i,
  input  logic                   tag_mem_i,
  input  logic                   tag_pc_i,
  output logic                   tag_o,
  output logic                   tag_we_o,
  output logic                   exc_req_o,
  output logic [CAUSE_WIDTH-1:0] exc_cause_o,
  input  logic                   exc_ack_i,
  output logic                   stall_o,
  output logic [CNT_WIDTH-1:0]   viol_cnt_o,
  input  logic                   viol_clr_i
);

  dift_class_e            cls;
  dift_tags_t             tags;
  dift_state_e            state_q;
  logic [TCR_WIDTH-1:0]   viol_d;
  logic                   viol_any;
  logic [CAUSE_WIDTH-1:0] cause_d, cause_q;
  logic [1:0]             mode;
  logic                   op_a, op_b, op_old;
  logic                   tag_d, tag_q, tag_we_q, exc_req_q;
  logic                   enter_req;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   unused_tpr;

  assign cls        = dift_class_e'(class_i);
  assign tags       = '{rs1: tag_rs1_i, rs2: tag_rs2_i, rd_old: tag_rd_old_i,
                        mem: tag_mem_i, pc: tag_pc_i};
  assign unused_tpr = tpr_i[14];

  always_comb begin
    viol_d = '0;
    unique case (cls)
      CLASS_INT: begin
        viol_d[INT_CHECK_S1] = tcr_i[INT_CHECK_S1] & tags.rs1;
        viol_d[INT_CHECK_S2] = tcr_i[INT_CHECK_S2] & tags.rs2;
        viol_d[INT_CHECK_D]  = tcr_i[INT_CHECK_D]  & tags.rd_old;
      end
      CLASS_BRANCH: begin
        viol_d[BRANCH_CHECK_S1] = tcr_i[BRANCH_CHECK_S1] & tags.rs1;
        viol_d[BRANCH_CHECK_S2] = tcr_i[BRANCH_CHECK_S2] & tags.rs2;
      end
      CLASS_JUMP: viol_d[JUMP_CHECK_S1] = tcr_i[JUMP_CHECK_S1] & tags.rs1;
      CLASS_SHIFT: begin
        viol_d[SHIFT_CHECK_S1] = tcr_i[SHIFT_CHECK_S1] & tags.rs1;
        viol_d[SHIFT_CHECK_S2] = tcr_i[SHIFT_CHECK_S2] & tags.rs2;
        viol_d[SHIFT_CHECK_D]  = tcr_i[SHIFT_CHECK_D]  & tags.rd_old;
      end
      CLASS_CMP: begin
        viol_d[CMP_CHECK_S1] = tcr_i[CMP_CHECK_S1] & tags.rs1;
        viol_d[CMP_CHECK_S2] = tcr_i[CMP_CHECK_S2] & tags.rs2;
        viol_d[CMP_CHECK_D]  = tcr_i[CMP_CHECK_D]  & tags.rd_old;
      end
      CLASS_LOGICAL: begin
        viol_d[LOGICAL_CHECK_S1] = tcr_i[LOGICAL_CHECK_S1] & tags.rs1;
        viol_d[LOGICAL_CHECK_S2] = tcr_i[LOGICAL_CHECK_S2] & tags.rs2;
        viol_d[LOGICAL_CHECK_D]  = tcr_i[LOGICAL_CHECK_D]  & tags.rd_old;
      end
      CLASS_LOAD: begin
        viol_d[LOAD_CHECK_S]  = tcr_i[LOAD_CHECK_S]  & tags.mem;
        viol_d[LOAD_CHECK_SA] = tcr_i[LOAD_CHECK_SA] & tags.rs1;
        viol_d[LOAD_CHECK_D]  = tcr_i[LOAD_CHECK_D]  & tags.rd_old;
      end
      CLASS_STORE: begin
        viol_d[STORE_CHECK_S]  = tcr_i[STORE_CHECK_S]  & tags.rs2;
        viol_d[STORE_CHECK_D]  = tcr_i[STORE_CHECK_D]  & tags.mem;
        viol_d[STORE_CHECK_DA] = tcr_i[STORE_CHECK_DA] & tags.rs1;
      end
    endcase
    viol_d[EXECUTE_PC] = tcr_i[EXECUTE_PC] & tags.pc;
  end

  riscv_dift_prio_enc #(
    .WIDTH     (TCR_WIDTH),
    .IDX_WIDTH (CAUSE_WIDTH)
  ) u_prio_enc (
    .vec_i (viol_d),
    .idx_o (cause_d),
    .any_o (viol_any)
  );

  // Memory classes swap in the memory tag and gate address/data tags by TPR enables.
  always_comb begin
    mode   = ALU_MODE_OLD;
    op_a   = tags.rs1;
    op_b   = tags.rs2;
    op_old = tags.rd_old;
    unique case (cls)
      CLASS_INT:     mode = {tpr_i[TPR_INT_HIGH],     tpr_i[TPR_INT_LOW]};
      CLASS_BRANCH:  mode = ALU_MODE_OLD;
      CLASS_JUMP:    mode = {tpr_i[TPR_JUMP_HIGH],    tpr_i[TPR_JUMP_LOW]};
      CLASS_SHIFT:   mode = {tpr_i[TPR_SHIFT_HIGH],   tpr_i[TPR_SHIFT_LOW]};
      CLASS_CMP:     mode = {tpr_i[TPR_CMP_HIGH],     tpr_i[TPR_CMP_LOW]};
      CLASS_LOGICAL: mode = {tpr_i[TPR_LOGICAL_HIGH], tpr_i[TPR_LOGICAL_LOW]};
      CLASS_LOAD: begin
        mode = {tpr_i[TPR_LOAD_HIGH], tpr_i[TPR_LOAD_LOW]};
        op_a = tags.mem;
        op_b = tags.rs1 & tpr_i[TPR_LOAD_ADDR_EN];
      end
      CLASS_STORE: begin
        mode   = {tpr_i[TPR_STORE_HIGH], tpr_i[TPR_STORE_LOW]};
        op_a   = tags.rs2 & tpr_i[TPR_STORE_DATA_EN];
        op_b   = tags.rs1 & tpr_i[TPR_STORE_ADDR_EN];
        op_old = tags.mem;
      end
    endcase
    tag_d = prop_result(mode, op_a, op_b, op_old);
  end

  assign enter_req = (state_q == RUN) && valid_i && viol_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      tag_q     <= 1'b0;
      tag_we_q  <= 1'b0;
      exc_req_q <= 1'b0;
      cause_q   <= '0;
      cnt_q     <= '0;
    end else begin
      tag_we_q <= 1'b0;
      if (viol_clr_i) begin
        cnt_q <= '0;
      end else if (enter_req && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      unique case (state_q)
        RUN: begin
          if (valid_i) begin
            tag_q    <= tag_d;
            tag_we_q <= (cls != CLASS_BRANCH) && !viol_any;
            if (viol_any) begin
              state_q   <= REQ;
              exc_req_q <= 1'b1;
              cause_q   <= cause_d;
            end
          end
        end
        REQ: begin
          if (exc_ack_i) begin
            state_q   <= FLUSH;
            exc_req_q <= 1'b0;
            cause_q   <= '0;
          end
        end
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign tag_o       = tag_q;
  assign tag_we_o    = tag_we_q;
  assign exc_req_o   = exc_req_q;
  assign exc_cause_o = cause_q;
  assign stall_o     = (state_q != RUN);
  assign viol_cnt_o  = cnt_q;

endmodule

// File: tb/tb_riscv_dift_tag_unit.sv
// Scoreboard bench for riscv_dift_tag_unit: directed policy cases plus random
// traffic against a table-driven reference model of the DIFT rules.
module tb_riscv_dift_tag_unit;

  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] tcr_i;
  logic [17:0] tpr_i;
  logic        valid_i;
  logic [2:0]  class_i;
  logic        tag_rs1_i, tag_rs2_i, tag_rd_old_i, tag_mem_i, tag_pc_i;
  logic        tag_o, tag_we_o, exc_req_o, exc_ack_i, stall_o, viol_clr_i;
  logic [4:0]  exc_cause_o;
  logic [1:0]  viol_cnt_o;

  riscv_dift_tag_unit #(.CNT_WIDTH(2), .CAUSE_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .tcr_i(tcr_i), .tpr_i(tpr_i), .valid_i(valid_i),
    .class_i(class_i), .tag_rs1_i(tag_rs1_i), .tag_rs2_i(tag_rs2_i),
    .tag_rd_old_i(tag_rd_old_i), .tag_mem_i(tag_mem_i), .tag_pc_i(tag_pc_i),
    .tag_o(tag_o), .tag_we_o(tag_we_o), .exc_req_o(exc_req_o),
    .exc_cause_o(exc_cause_o), .exc_ack_i(exc_ack_i), .stall_o(stall_o),
    .viol_cnt_o(viol_cnt_o), .viol_clr_i(viol_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_exc; bit tag; int cause; } ev_t;
  typedef struct { bit stall; bit req; int cnt; int cause; } cyc_t;
  ev_t  evq[$];
  cyc_t cycq[$];

  int n_vec = 0;
  int n_err = 0;
  int m_phase = 0;  // 0 running, 1 awaiting ack, 2 flush
  int m_cnt = 0;
  int m_cause = 0;
  bit req_prev = 1'b0;

  // Check bit -> owning class and tag source (0 rs1, 1 rs2, 2 rd_old, 3 mem); bit 21 is the PC check.
  int CHK_CLS [21] = '{0,0,0, 1,1, 2, 3,3,3, 4,4,4, 5,5,5, 6,6,6, 7,7,7};
  int CHK_SRC [21] = '{0,1,2, 0,1, 0, 0,1,2, 0,1,2, 0,1,2, 3,0,2, 1,3,0};
  int TPR_LO  [8]  = '{0, 0, 2, 4, 6, 8, 12, 10};

  function automatic int exp_cause(logic [21:0] tcr, int cls, bit r1, bit r2, bit rd, bit mem, bit pc);
    bit src [4];
    src = '{r1, r2, rd, mem};
    for (int i = 0; i < 22; i++) begin
      if (tcr[i]) begin
        if (i == 21) begin
          if (pc) return 21;
        end else if (CHK_CLS[i] == cls && src[CHK_SRC[i]]) begin
          return i;
        end
      end
    end
    return -1;
  endfunction

  function automatic bit exp_tag(logic [17:0] tpr, int cls, bit r1, bit r2, bit rd, bit mem);
    int lo, m;
    bit a, b, old;
    lo = TPR_LO[cls];
    m = 2 * int'(tpr[lo+1]) + int'(tpr[lo]);
    a = r1; b = r2; old = rd;
    if (cls == 6) begin a = mem; b = r1 & tpr[16]; end
    if (cls == 7) begin a = r2 & tpr[15]; b = r1 & tpr[17]; old = mem; end
    case (m)
      0:       return old;
      1:       return a & b;
      2:       return a | b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    valid_i = 0; class_i = 0; tcr_i = '0; tpr_i = '0; exc_ack_i = 0; viol_clr_i = 0;
    tag_rs1_i = 0; tag_rs2_i = 0; tag_rd_old_i = 0; tag_mem_i = 0; tag_pc_i = 0;
  endtask

  // Called at negedge+1: predicts the effect of the coming posedge, then returns at the next negedge+1.
  task automatic step();
    ev_t  e;
    cyc_t c;
    int   cz, ph;
    bit   enter;
    ph = m_phase;
    enter = 0;
    if (ph == 0 && valid_i) begin
      cz = exp_cause(tcr_i, int'(class_i), tag_rs1_i, tag_rs2_i, tag_rd_old_i, tag_mem_i, tag_pc_i);
      if (cz >= 0) begin
        e = '{1'b1, 1'b0, cz};
        evq.push_back(e);
        m_phase = 1; m_cause = cz; enter = 1;
      end else if (class_i != 3'd1) begin
        e = '{1'b0, exp_tag(tpr_i, int'(class_i), tag_rs1_i, tag_rs2_i, tag_rd_old_i, tag_mem_i), 0};
        evq.push_back(e);
      end
    end
    if (ph == 1 && exc_ack_i) m_phase = 2;
    if (ph == 2) m_phase = 0;
    if (viol_clr_i) m_cnt = 0;
    else if (enter && m_cnt < CNT_MAX) m_cnt++;
    c = '{m_phase != 0, m_phase == 1, m_cnt, m_cause};
    cycq.push_back(c);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cyc_t c;
    ev_t  e;
    if (rst_n) begin
      if (cycq.size() > 0) begin
        c = cycq.pop_front();
        check("stall", int'(stall_o), int'(c.stall));
        check("exc_req", int'(exc_req_o), int'(c.req));
        check("viol_cnt", int'(viol_cnt_o), c.cnt);
        if (c.req) check("exc_cause_held", int'(exc_cause_o), c.cause);
      end
      if (tag_we_o) begin
        if (evq.size() == 0 || evq[0].is_exc) begin
          n_vec++; n_err++;
          $display("FAIL tag_write: unexpected write of tag %0d (t=%0t)", tag_o, $time);
        end else begin
          e = evq.pop_front();
          check("tag", int'(tag_o), int'(e.tag));
        end
      end
      if (exc_req_o && !req_prev) begin
        if (evq.size() == 0 || !evq[0].is_exc) begin
          n_vec++; n_err++;
          $display("FAIL exc_raise: unexpected request cause %0d (t=%0t)", exc_cause_o, $time);
        end else begin
          e = evq.pop_front();
          check("exc_cause", int'(exc_cause_o), e.cause);
        end
      end
    end
    req_prev = exc_req_o;
  end

  task automatic check_all_zero(string tagname);
    check({tagname, "_tag"}, int'(tag_o), 0);
    check({tagname, "_we"}, int'(tag_we_o), 0);
    check({tagname, "_req"}, int'(exc_req_o), 0);
    check({tagname, "_cause"}, int'(exc_cause_o), 0);
    check({tagname, "_stall"}, int'(stall_o), 0);
    check({tagname, "_cnt"}, int'(viol_cnt_o), 0);
  endtask

  task automatic ack_and_flush();
    idle(); exc_ack_i = 1; step();
    check("ack_req_drop", int'(exc_req_o), 0);
    check("flush_stall", int'(stall_o), 1);
    idle(); step();
    check("run_stall", int'(stall_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); #1;

    // Propagation: int OR, load CLEAR, load AND
    idle(); valid_i = 1; class_i = 0; tpr_i = 18'b10; tag_rs1_i = 1; step();
    check("int_or_tag", int'(tag_o), 1);
    check("int_or_we", int'(tag_we_o), 1);
    check("int_or_req", int'(exc_req_o), 0);
    idle(); valid_i = 1; class_i = 6; tpr_i = 18'h3000; tag_mem_i = 1; step();
    check("load_clear_tag", int'(tag_o), 0);
    idle(); valid_i = 1; class_i = 6; tpr_i = 18'h11000; tag_rs1_i = 1; tag_mem_i = 1; step();
    check("load_and_tag", int'(tag_o), 1);

    // Violation priority and held cause
    idle(); valid_i = 1; class_i = 0; tcr_i = 22'h200001; tag_rs1_i = 1; tag_pc_i = 1; step();
    check("prio_req", int'(exc_req_o), 1);
    check("prio_cause", int'(exc_cause_o), 0);
    check("prio_we", int'(tag_we_o), 0);
    check("prio_stall", int'(stall_o), 1);
    check("prio_cnt", int'(viol_cnt_o), 1);
    for (int k = 0; k < 2; k++) begin
      idle(); valid_i = 1; class_i = 7; tcr_i = 22'h100000; tag_rs1_i = 1; step();
      check("held_cause", int'(exc_cause_o), 0);
    end
    ack_and_flush();

    // Store address check, branch check
    idle(); valid_i = 1; class_i = 7; tcr_i = 22'h100000; tag_rs1_i = 1; step();
    check("store_da_cause", int'(exc_cause_o), 20);
    ack_and_flush();
    idle(); valid_i = 1; class_i = 1; tcr_i = 22'h8; tag_rs1_i = 1; step();
    check("branch_cause", int'(exc_cause_o), 3);
    check("branch_we", int'(tag_we_o), 0);
    ack_and_flush();

    // Counter saturation then clear winning over an increment
    idle(); valid_i = 1; class_i = 0; tcr_i = 22'h1; tag_rs1_i = 1; step();
    check("cnt_saturated", int'(viol_cnt_o), 3);
    ack_and_flush();
    idle(); valid_i = 1; class_i = 0; tcr_i = 22'h1; tag_rs1_i = 1; viol_clr_i = 1; step();
    check("cnt_clr_wins", int'(viol_cnt_o), 0);
    check("clr_req", int'(exc_req_o), 1);

    // Asynchronous reset while a request is pending
    #1 rst_n = 0;
    #1 check_all_zero("async_rst");
    evq.delete(); cycq.delete();
    m_phase = 0; m_cnt = 0; m_cause = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); #1;
    idle(); valid_i = 1; class_i = 0; tpr_i = 18'b01; tag_rs1_i = 1; tag_rs2_i = 1; step();
    check("post_rst_we", int'(tag_we_o), 1);
    check("post_rst_tag", int'(tag_o), 1);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      valid_i      = ($urandom_range(0, 3) != 0);
      class_i      = 3'($urandom_range(0, 7));
      tcr_i        = ($urandom_range(0, 5) == 0) ? '0 : 22'($urandom & $urandom & $urandom);
      tpr_i        = 18'($urandom);
      tag_rs1_i    = 1'($urandom);
      tag_rs2_i    = 1'($urandom);
      tag_rd_old_i = 1'($urandom);
      tag_mem_i    = 1'($urandom);
      tag_pc_i     = 1'($urandom);
      exc_ack_i    = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      viol_clr_i   = ($urandom_range(0, 15) == 0);
      step();
    end

    for (int n = 0; n < 3; n++) begin
      idle(); exc_ack_i = 1; step();
    end
    idle();
    check("events_pending", evq.size(), 0);
    check("cycles_pending", cycq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
